// File: rtl/gcd_pkg.sv
// Shared types for the gcd arbiter: operand width and the handshake-sequencer state encoding.
package gcd_pkg;

   localparam int GCD_W = 16;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SEND_A  = 3'd1,
      S_DROP_A  = 3'd2,
      S_SEND_B  = 3'd3,
      S_RELEASE = 3'd4,
      S_RESPOND = 3'd5
   } arb_state_t;

   // gcd(x,0)=x and gcd(0,0)=0 collapse to a plain OR when one side is zero.
   function automatic logic [GCD_W-1:0] zero_pair_result(input logic [GCD_W-1:0] a,
                                                         input logic [GCD_W-1:0] b);
      return a | b;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester strictly after ptr_i, wrapping.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] idx_o
);

   localparam int IW = $clog2(N);

   logic found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
         if (!found && req_i[(int'(ptr_i) + i) % N]) begin
            found                            = 1'b1;
            gnt_o[(int'(ptr_i) + i) % N]     = 1'b1;
            idx_o                            = IW'((int'(ptr_i) + i) % N);
         end
      end
   end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one serial gcd core between N_CLIENTS req/ack clients with round-robin arbitration.
// Optional build macro GCD_ARB_ZERO_BYPASS_EN answers pairs with a zero operand without the core.
module gcd_arbiter
   import gcd_pkg::*;
#(
   parameter int N_CLIENTS = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [N_CLIENTS-1:0]               cli_req,
   input  logic [N_CLIENTS-1:0][GCD_W-1:0]    cli_a,
   input  logic [N_CLIENTS-1:0][GCD_W-1:0]    cli_b,
   output logic [N_CLIENTS-1:0]               cli_ack,
   output logic [GCD_W-1:0]                   cli_c,
   output logic                               gcd_req,
   output logic [GCD_W-1:0]                   gcd_ab,
   input  logic                               gcd_ack,
   input  logic [GCD_W-1:0]                   gcd_c,
   output logic                               busy,
   output logic [$clog2(N_CLIENTS)-1:0]       grant_id
);

   localparam int            IW      = $clog2(N_CLIENTS);
   localparam logic [IW-1:0] PTR_RST = IW'(N_CLIENTS - 1);

   arb_state_t           state_q, state_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [IW-1:0]        grant_q, grant_d;
   logic                 drop_q, drop_d;
   logic [GCD_W-1:0]     a_q, a_d;
   logic [GCD_W-1:0]     b_q, b_d;
   logic [GCD_W-1:0]     res_q, res_d;
   logic [N_CLIENTS-1:0] eligible;
   logic [N_CLIENTS-1:0] arb_gnt;
   logic [IW-1:0]        arb_idx;

   assign eligible = cli_req & ~cli_ack;

   rr_arbiter #(.N(N_CLIENTS)) u_rr (
      .req_i (eligible),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      drop_d  = drop_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;

      // A client that lets go mid-operation forfeits its result; remember it until S_RESPOND.
      if (state_q != S_IDLE && state_q != S_RESPOND)
         drop_d = drop_q | ~cli_req[grant_q];

      case (state_q)
         S_IDLE: begin
            if (|arb_gnt) begin
               grant_d = arb_idx;
               a_d     = cli_a[arb_idx];
               b_d     = cli_b[arb_idx];
               drop_d  = 1'b0;
`ifdef GCD_ARB_ZERO_BYPASS_EN
               if (cli_a[arb_idx] == '0 || cli_b[arb_idx] == '0) begin
                  res_d   = zero_pair_result(cli_a[arb_idx], cli_b[arb_idx]);
                  state_d = S_RESPOND;
               end else begin
                  state_d = S_SEND_A;
               end
`else
               state_d = S_SEND_A;
`endif
            end
         end
         S_SEND_A: if (gcd_ack)  state_d = S_DROP_A;
         S_DROP_A: if (!gcd_ack) state_d = S_SEND_B;
         S_SEND_B: begin
            if (gcd_ack) begin
               res_d   = gcd_c;
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: if (!gcd_ack) state_d = S_RESPOND;
         S_RESPOND: begin
            if (drop_q || !cli_req[grant_q]) begin
               state_d = S_IDLE;
               ptr_d   = grant_q;
               grant_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ptr_q   <= PTR_RST;
         grant_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         drop_q  <= drop_d;
      end
   end

   // Operand/result holding registers need no reset: every output gates them by state.
   always_ff @(posedge clk) begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
   end

   always_comb begin
      busy     = (state_q != S_IDLE);
      grant_id = grant_q;
      gcd_req  = (state_q == S_SEND_A) || (state_q == S_SEND_B);
      case (state_q)
         S_SEND_A, S_DROP_A:  gcd_ab = a_q;
         S_SEND_B, S_RELEASE: gcd_ab = b_q;
         default:             gcd_ab = '0;
      endcase
      cli_ack = '0;
      cli_c   = '0;
      if (state_q == S_RESPOND && !drop_q) begin
         cli_ack[grant_q] = 1'b1;
         cli_c            = res_q;
      end
   end

endmodule
